// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) round-robin scheduler:
// opcodes, FSM state encoding, datapath widths and parity helpers.
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Check bits {p3, p2, p1} for data d[4:1]; pt = 1 selects odd parity.
    function automatic logic [2:0] hamming_parity(input logic [4:1] d, input logic pt);
        logic [2:0] p;
        p[0] = d[1] ^ d[2] ^ d[4] ^ pt;
        p[1] = d[1] ^ d[3] ^ d[4] ^ pt;
        p[2] = d[2] ^ d[3] ^ d[4] ^ pt;
        return p;
    endfunction

    // Syndrome {s3, s2, s1}; a nonzero value is the position of the flipped bit.
    function automatic logic [2:0] hamming_syndrome(input logic [7:1] c, input logic pt);
        logic [2:0] s;
        s[0] = c[1] ^ c[3] ^ c[5] ^ c[7] ^ pt;
        s[1] = c[2] ^ c[3] ^ c[6] ^ c[7] ^ pt;
        s[2] = c[4] ^ c[5] ^ c[6] ^ c[7] ^ pt;
        return s;
    endfunction

endpackage

// File: rtl/hamming74_core.sv
// Combinational Hamming(7,4) datapath: encodes operand[4:1] and, in parallel,
// decodes/corrects operand[7:1]. The caller picks the result by opcode.
// Ports:
//   operand_i  [7:1] operand (encode reads [4:1])
//   ptype_i          parity type, 0 even / 1 odd
//   enc_cw_o   [7:1] codeword {d4,d3,d2,p3,d1,p2,p1}
//   dec_data_o [4:1] corrected data {c7,c6,c5,c3}
//   dec_err_o        syndrome nonzero (single-bit error corrected)
module hamming74_core
    import hamming_pkg::*;
(
    input  logic [7:1] operand_i,
    input  logic       ptype_i,
    output logic [7:1] enc_cw_o,
    output logic [4:1] dec_data_o,
    output logic       dec_err_o
);

    logic [2:0] par_s;
    logic [2:0] syn_s;
    logic [7:1] corr_s;

    // Encode and syndrome-based single-bit correction.
    always_comb begin
        par_s    = hamming_parity(operand_i[4:1], ptype_i);
        enc_cw_o = {operand_i[4], operand_i[3], operand_i[2], par_s[2],
                    operand_i[1], par_s[1], par_s[0]};
        syn_s    = hamming_syndrome(operand_i, ptype_i);
        corr_s   = operand_i;
        for (int k = 1; k <= 7; k++) begin
            corr_s[k] = operand_i[k] ^ (syn_s == 3'(k));
        end
        dec_data_o = {corr_s[7], corr_s[6], corr_s[5], corr_s[3]};
        dec_err_o  = (syn_s != 3'b000);
    end

endmodule

// File: rtl/hamming_rr_scheduler.sv
// Two-port scheduler sharing one Hamming(7,4) core. A round-robin arbiter
// accepts one request in IDLE, the core result is registered in EXEC, and
// the response is held in RESP until the owning port takes it.
// Ports:
//   req_valid/req_ready [1:0]  per-port request handshake
//   req_op/req_ptype    [1:0]  per-port opcode (0 enc, 1 dec) and parity type
//   req_data0/1         [7:1]  per-port operand
//   resp_valid/ready    [1:0]  one-hot response handshake (owning port)
//   resp_data/resp_err         shared response bus
//   err_count/clr_count        saturating corrected-error counter and clear
//   busy                       FSM not in IDLE
module hamming_rr_scheduler
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_ptype,
    input  logic [7:1]       req_data0,
    input  logic [7:1]       req_data1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [7:1]       resp_data,
    output logic             resp_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             rr_ptr_q;
    logic             owner_q;
    logic             op_q;
    logic             ptype_q;
    logic [7:1]       operand_q;
    logic [1:0]       resp_valid_q;
    logic [7:1]       resp_data_q;
    logic             resp_err_q;
    logic [CNT_W-1:0] err_count_q;
    logic             busy_q;

    logic             grant_s;
    logic             accept_s;
    logic             resp_hs_s;
    logic [7:1]       enc_cw_s;
    logic [4:1]       dec_data_s;
    logic             dec_err_s;

    hamming74_core u_core (
        .operand_i  (operand_q),
        .ptype_i    (ptype_q),
        .enc_cw_o   (enc_cw_s),
        .dec_data_o (dec_data_s),
        .dec_err_o  (dec_err_s)
    );

    // Round-robin grant; ready is masked during reset so nothing is accepted then.
    always_comb begin
        grant_s   = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b10) begin
            grant_s = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant_s = rr_ptr_q;
        end else begin
            grant_s = 1'b0;
        end
        accept_s = (state_q == IDLE) && (req_valid != 2'b00) && !rst;
        if (accept_s) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        resp_hs_s = (resp_valid_q & resp_ready) != 2'b00;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = resp_hs_s ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, response registers and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            op_q         <= OP_ENC;
            ptype_q      <= 1'b0;
            operand_q    <= 7'd0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= 7'd0;
            resp_err_q   <= 1'b0;
            err_count_q  <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept_s) begin
                owner_q   <= grant_s;
                op_q      <= req_op[grant_s];
                ptype_q   <= req_ptype[grant_s];
                operand_q <= grant_s ? req_data1 : req_data0;
                rr_ptr_q  <= ~grant_s;
            end
            if (state_q == EXEC) begin
                resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                resp_data_q  <= (op_q == OP_DEC) ? {3'b000, dec_data_s} : enc_cw_s;
                resp_err_q   <= (op_q == OP_DEC) && dec_err_s;
            end else if (state_q == RESP && resp_hs_s) begin
                resp_valid_q <= 2'b00;
            end
            // Clear takes priority over an increment in the same cycle.
            if (clr_count) begin
                err_count_q <= {CNT_W{1'b0}};
            end else if (state_q == EXEC && op_q == OP_DEC && dec_err_s
                         && err_count_q != {CNT_W{1'b1}}) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hamming_rr_scheduler.sv
module tb_hamming_rr_scheduler;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [1:0]       req_ptype = 2'b00;
    logic [7:1]       req_data0 = 7'd0;
    logic [7:1]       req_data1 = 7'd0;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready = 2'b11;
    logic [7:1]       resp_data;
    logic             resp_err;
    logic [CNT_W-1:0] err_count;
    logic             clr_count = 1'b0;
    logic             busy;

    typedef struct {
        logic       port;
        logic [7:1] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    hamming_rr_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ptype(req_ptype),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .err_count(err_count), .clr_count(clr_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic push(input logic p, input logic [7:1] d, input logic e);
        exp_t x;
        x.port = p; x.data = d; x.err = e;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: compares on every completed response handshake.
    always @(negedge clk) begin
        if ((resp_valid & resp_ready) != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got valid %b data %b with none expected", resp_valid, resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(onehot(e.port)));
                check("resp_data", 32'(resp_data), 32'(e.data));
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single request on one port with resp_ready high; optional clr during EXEC.
    task automatic do_op(input logic p, input logic op, input logic pt, input logic [7:1] d,
                         input logic [7:1] exp_d, input logic exp_e, input int exp_cnt,
                         input logic clr_exec);
        int t;
        #1;
        req_op[p] = op;
        req_ptype[p] = pt;
        if (p) req_data1 = d; else req_data0 = d;
        req_valid[p] = 1'b1;
        @(negedge clk);
        t = 0;
        while (!req_ready[p] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[p]) begin
            check("accept_timeout", 32'(req_ready), 32'(onehot(p)));
            req_valid[p] = 1'b0;
        end else begin
            push(p, exp_d, exp_e);
            @(posedge clk);
            #1;
            req_valid[p] = 1'b0;
            clr_count = clr_exec;
            @(negedge clk);
            check("exec_no_resp", 32'(resp_valid), 32'(2'b00));
            @(posedge clk);
            #1;
            clr_count = 1'b0;
            @(negedge clk);
            check("lat_resp_valid", 32'(resp_valid), 32'(onehot(p)));
            check("err_count", 32'(err_count), 32'(exp_cnt));
            @(posedge clk);
        end
    endtask

    initial begin
        // Reset values, with both ports already requesting.
        req_op = 2'b10;
        req_ptype = 2'b00;
        req_data0 = 7'b0001011;
        req_data1 = 7'b1010100;
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(2'b00));
        check("rst_resp_valid", 32'(resp_valid), 32'(2'b00));
        check("rst_resp_data", 32'(resp_data), 32'(7'd0));
        check("rst_resp_err", 32'(resp_err), 32'(1'b0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        rst = 1'b0;
        #1;
        check("first_grant_p0", 32'(req_ready), 32'(2'b01));
        push(1'b0, 7'b1010101, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        @(negedge clk);
        check("exec_busy", 32'(busy), 32'(1'b1));
        check("exec_ready_low", 32'(req_ready), 32'(2'b00));
        @(negedge clk);
        check("p0_resp_valid", 32'(resp_valid), 32'(2'b01));
        check("resp_ready_low", 32'(req_ready), 32'(2'b00));
        @(posedge clk);
        @(negedge clk);
        check("second_grant_p1", 32'(req_ready), 32'(2'b10));
        push(1'b1, 7'b0001011, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("p1_resp_valid", 32'(resp_valid), 32'(2'b10));
        check("cnt_after_p1", 32'(err_count), 32'(1));
        @(posedge clk);

        // Both ports held valid: grants alternate.
        #1;
        req_op = 2'b00;
        req_ptype = 2'b01;
        req_data0 = 7'b0000110;
        req_data1 = 7'b0000001;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = 1'(i % 2);
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(onehot(g)));
            push(g, g ? 7'b0000111 : 7'b0111000, 1'b0);
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;

        // Response stall: outputs hold, nothing accepted.
        req_op = 2'b01;
        req_ptype = 2'b01;
        req_data0 = 7'b0111000;
        req_data1 = 7'b0000001;
        resp_ready = 2'b00;
        req_valid = 2'b11;
        @(negedge clk);
        check("stall_grant_p0", 32'(req_ready), 32'(2'b01));
        push(1'b0, 7'b0000110, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'(2'b01));
            check("stall_data", 32'(resp_data), 32'(7'b0000110));
            check("stall_err", 32'(resp_err), 32'(1'b0));
            check("stall_busy", 32'(busy), 32'(1'b1));
            check("stall_ready", 32'(req_ready), 32'(2'b00));
        end
        @(posedge clk);
        #1;
        resp_ready = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", 32'(busy), 32'(1'b0));
        check("release_grant_p1", 32'(req_ready), 32'(2'b10));
        push(1'b1, 7'b0000111, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);

        // Counter clear, saturation, clear beating a same-cycle increment.
        #1;
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        @(negedge clk);
        check("clr_count", 32'(err_count), 32'(0));
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            if (k % 2 == 1)
                do_op(1'b1, 1'b1, 1'b0, 7'b1010100, 7'b0001011, 1'b1, (k > 3) ? 3 : k, 1'b0);
            else
                do_op(1'b0, 1'b1, 1'b1, 7'b1111000, 7'b0000110, 1'b1, (k > 3) ? 3 : k, 1'b0);
        end
        do_op(1'b1, 1'b1, 1'b0, 7'b1010100, 7'b0001011, 1'b1, 0, 1'b1);
        do_op(1'b0, 1'b1, 1'b0, 7'b1010100, 7'b0001011, 1'b1, 1, 1'b0);

        // Reset during EXEC: dropped, request held through reset is accepted after.
        #1;
        req_op[0] = 1'b0;
        req_ptype[0] = 1'b0;
        req_data0 = 7'b0001011;
        req_valid = 2'b01;
        @(negedge clk);
        check("pre_rst_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'(2'b00));
        check("arst_busy", 32'(busy), 32'(1'b0));
        check("arst_err_count", 32'(err_count), 32'(0));
        check("arst_req_ready", 32'(req_ready), 32'(2'b00));
        @(negedge clk);
        @(negedge clk);
        check("arst_no_resp", 32'(resp_valid), 32'(2'b00));
        rst = 1'b0;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'(2'b01));
        push(1'b0, 7'b1010101, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_resp", 32'(resp_valid), 32'(2'b01));
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
